// File: rtl/arb_req_mux_if.sv
// arb_req_mux_if: request, arbiter, downstream and response signals of the arbitrated request mux
// Parameters: NUM_REQUESTERS request ports, DATA_W request payload width, RSP_W response payload width
// Signals (named from the mux's point of view):
//   i_req_valid/i_req_data/o_req_ready  per-port requests, port k data at [k*DATA_W +: DATA_W]
//   i_req_last                          per-port last beat (only with ARB_MUX_BURST_EN)
//   o_arb_requests/i_arb_grants         to/from the round-robin arbiter
//   o_dn_valid/o_dn_data/o_dn_src/i_dn_ready  single downstream request port
//   i_rsp_valid/i_rsp_data/o_rsp_ready  in-order downstream responses
//   o_rsp_valid/o_rsp_data/i_rsp_ready  per-port responses back to requesters
//   o_busy/o_orphan_err                 status
// Modports: slave is the mux itself, master is the surrounding environment.
interface arb_req_mux_if #(
   parameter int NUM_REQUESTERS = 4,
   parameter int DATA_W = 32,
   parameter int RSP_W = 32
);
   localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
   logic [NUM_REQUESTERS-1:0] i_req_valid;
   logic [NUM_REQUESTERS*DATA_W-1:0] i_req_data;
`ifdef ARB_MUX_BURST_EN
   logic [NUM_REQUESTERS-1:0] i_req_last;
`endif
   logic [NUM_REQUESTERS-1:0] o_req_ready;
   logic [NUM_REQUESTERS-1:0] o_arb_requests;
   logic [NUM_REQUESTERS-1:0] i_arb_grants;
   logic o_dn_valid;
   logic [DATA_W-1:0] o_dn_data;
   logic [IDX_W-1:0] o_dn_src;
   logic i_dn_ready;
   logic i_rsp_valid;
   logic [RSP_W-1:0] i_rsp_data;
   logic o_rsp_ready;
   logic [NUM_REQUESTERS-1:0] o_rsp_valid;
   logic [RSP_W-1:0] o_rsp_data;
   logic [NUM_REQUESTERS-1:0] i_rsp_ready;
   logic o_busy;
   logic o_orphan_err;
   modport slave (
`ifdef ARB_MUX_BURST_EN
      input i_req_last,
`endif
      input i_req_valid, i_req_data, i_arb_grants, i_dn_ready, i_rsp_valid, i_rsp_data, i_rsp_ready,
      output o_req_ready, o_arb_requests, o_dn_valid, o_dn_data, o_dn_src, o_rsp_ready, o_rsp_valid,
      output o_rsp_data, o_busy, o_orphan_err
   );
   modport master (
`ifdef ARB_MUX_BURST_EN
      output i_req_last,
`endif
      output i_req_valid, i_req_data, i_arb_grants, i_dn_ready, i_rsp_valid, i_rsp_data, i_rsp_ready,
      input o_req_ready, o_arb_requests, o_dn_valid, o_dn_data, o_dn_src, o_rsp_ready, o_rsp_valid,
      input o_rsp_data, o_busy, o_orphan_err
   );
endinterface

// File: rtl/arb_req_mux.sv
// arb_req_mux: request/response mux around a round-robin arbiter with an in-order source tag FIFO
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    arb_req_mux_if.slave: requests, arbiter request/grant, downstream port, responses, status
// Parameters: NUM_REQUESTERS, DATA_W, RSP_W, MAX_OUTSTANDING (tag FIFO depth, power of 2, >= 2)
// Build option: define ARB_MUX_BURST_EN to hold the lock across multi-beat bursts ended by i_req_last;
//   one tag is recorded per burst. Without it every accepted beat is one transaction.
module arb_req_mux #(
   parameter int NUM_REQUESTERS = 4,
   parameter int DATA_W = 32,
   parameter int RSP_W = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input logic clk,
   input logic rst_n,
   arb_req_mux_if.slave bus
);
   localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] tag_mem [MAX_OUTSTANDING];
   logic [PTR_W:0] wr_ptr, rd_ptr;
   logic [NUM_REQUESTERS-1:0] arb_req, win;
   logic [IDX_W-1:0] win_idx, head;
   logic fifo_full, fifo_empty, issue, last_beat, dn_hs, push, pop, orphan_q;
   // pointers carry a wrap bit so equal indices distinguish full from empty
   assign fifo_empty = wr_ptr == rd_ptr;
   assign fifo_full = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign head = tag_mem[rd_ptr[PTR_W-1:0]];
   assign issue = state_q == ISSUE;
   // masking requests while full is what keeps the tag FIFO from overflowing
   assign arb_req = (!issue && !fifo_full) ? bus.i_req_valid : '0;
   // a grant only counts where the port is actually requesting
   assign win = bus.i_arb_grants & arb_req;
`ifdef ARB_MUX_BURST_EN
   assign last_beat = bus.i_req_last[grant_q];
`else
   assign last_beat = 1'b1;
`endif
   assign dn_hs = issue && bus.i_req_valid[grant_q] && bus.i_dn_ready;
   assign push = dn_hs && last_beat;
   // the response side looks only at registered FIFO state, never at this cycle's push
   assign pop = !fifo_empty && bus.i_rsp_valid && bus.i_rsp_ready[head];
   always_comb begin
      win_idx = '0;
      for (int k = 0; k < NUM_REQUESTERS; k++)
         if (win[k]) win_idx = IDX_W'(k);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
      end
   end
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         IDLE:
            if (|win) begin
               state_d = ISSUE;
               grant_d = win_idx;
            end
         ISSUE:
            if (push) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      bus.o_arb_requests = arb_req;
      bus.o_dn_valid = issue && bus.i_req_valid[grant_q];
      bus.o_dn_data = issue ? bus.i_req_data[grant_q*DATA_W +: DATA_W] : '0;
      bus.o_dn_src = issue ? grant_q : '0;
      bus.o_req_ready = '0;
      bus.o_req_ready[grant_q] = issue && bus.i_dn_ready;
      bus.o_rsp_valid = '0;
      bus.o_rsp_valid[head] = !fifo_empty && bus.i_rsp_valid;
      // with nothing outstanding, responses are swallowed and flagged instead of stalling downstream
      bus.o_rsp_ready = fifo_empty || bus.i_rsp_ready[head];
      bus.o_rsp_data = bus.i_rsp_data;
      bus.o_busy = issue || !fifo_empty;
      bus.o_orphan_err = orphan_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         orphan_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (fifo_empty && bus.i_rsp_valid) orphan_q <= 1'b1;
      end
   end
   always_ff @(posedge clk)
      if (push) tag_mem[wr_ptr[PTR_W-1:0]] <= grant_q;
endmodule
